alu_arbiter: RTL and testbench

- Shares one instance of the existing 32-bit combinational alu between two requesters, e.g. the fetch/PC-increment path (req 0) and the execute path (req 1).
- Each requester has a valid/ready request channel. Grants are round-robin.
- The ALU result and flags go into a single-entry response register, tagged with the requester id and returned on one valid/ready response channel.
- One-cycle accept-to-response latency; full throughput when the response is drained every cycle.

---
 rtl/alu_arb_pkg.sv | 29 ++
 rtl/alu.sv | 35 +++
 rtl/alu.svh | 11 +
 rtl/rr_arb2.sv | 20 ++
 rtl/alu_arbiter.sv | 109 ++++++++++
 tb/tb_alu_arbiter.sv | 217 +++++++++++++++++++++
 6 files changed

// File: rtl/alu_arb_pkg.sv
// rtl/alu_arb_pkg.sv - shared types and constants for the two-port alu arbiter
`include "alu.svh"
package alu_arb_pkg;
  localparam int NREQ   = 2;
  localparam int DATA_W = 32;

  localparam logic [2:0] OP_ADD = `ALU_ADD;
  localparam logic [2:0] OP_SUB = `ALU_SUB;
  localparam logic [2:0] OP_AND = `ALU_AND;
  localparam logic [2:0] OP_OR  = `ALU_OR;
  localparam logic [2:0] OP_XOR = `ALU_XOR;
  localparam logic [2:0] OP_SLL = `ALU_SLL;
  localparam logic [2:0] OP_SRL = `ALU_SRL;
  localparam logic [2:0] OP_NOP = 3'b111;

  typedef struct packed {
    logic [2:0]        op;
    logic [DATA_W-1:0] x;
    logic [DATA_W-1:0] y;
  } alu_req_t;

  typedef struct packed {
    logic              id;
    logic [DATA_W-1:0] z;
    logic              equal;
    logic              overflow;
    logic              zero;
  } alu_rsp_t;
endpackage

// File: rtl/alu.sv
// rtl/alu.sv - 32-bit combinational alu; the unused op code yields z=0
`include "alu.svh"
module alu (
  input  logic [31:0] x,
  input  logic [31:0] y,
  input  logic [2:0]  op,
  output logic [31:0] z,
  output logic        equal,
  output logic        overflow,
  output logic        zero
);
  always_comb begin
    z        = '0;
    overflow = 1'b0;
    case (op)
      `ALU_ADD: begin
        z        = x + y;
        overflow = (x[31] == y[31]) && (z[31] != x[31]);
      end
      `ALU_SUB: begin
        z        = x - y;
        overflow = (x[31] != y[31]) && (z[31] != x[31]);
      end
      `ALU_AND: z = x & y;
      `ALU_OR:  z = x | y;
      `ALU_XOR: z = x ^ y;
      `ALU_SLL: z = x << y[4:0];
      `ALU_SRL: z = x >> y[4:0];
      default:  z = '0;
    endcase
  end

  assign equal = (x == y);
  assign zero  = (z == '0);
endmodule

// File: rtl/alu.svh
// rtl/alu.svh - op codes shared by the alu and its users
`ifndef ALU_SVH
`define ALU_SVH
`define ALU_ADD 3'b000
`define ALU_SUB 3'b001
`define ALU_AND 3'b010
`define ALU_OR  3'b011
`define ALU_XOR 3'b100
`define ALU_SLL 3'b101
`define ALU_SRL 3'b110
`endif

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - two-input round-robin grant, gated by response space
module rr_arb2 (
  input  logic [1:0] valid_i,
  input  logic       last_grant_i,
  input  logic       space_i,
  output logic [1:0] grant_o
);
  always_comb begin
    grant_o = 2'b00;
    if (space_i) begin
      case (valid_i)
        2'b01:   grant_o = 2'b01;
        2'b10:   grant_o = 2'b10;
        // On contention the requester that did not win last time goes first.
        2'b11:   grant_o = last_grant_i ? 2'b01 : 2'b10;
        default: grant_o = 2'b00;
      endcase
    end
  end
endmodule

// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - shares one alu between two requesters with a
// single-entry tagged response register and a saturating conflict counter
module alu_arbiter
  import alu_arb_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ*3-1:0]     req_op,
  input  logic [NREQ*WIDTH-1:0] req_x,
  input  logic [NREQ*WIDTH-1:0] req_y,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic                  rsp_id,
  output logic [WIDTH-1:0]      rsp_z,
  output logic                  rsp_equal,
  output logic                  rsp_overflow,
  output logic                  rsp_zero,
  output logic [CNT_W-1:0]      conflict_cnt
);
  alu_req_t   req [NREQ];
  alu_req_t   sel_req;
  alu_rsp_t   rsp_q, rsp_d;
  logic       rsp_valid_q, rsp_valid_d;
  logic       last_grant_q, last_grant_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [NREQ-1:0]  grant;
  logic       space, fire, sel;
  logic [DATA_W-1:0] alu_z;
  logic       alu_equal, alu_overflow, alu_zero;

  for (genvar i = 0; i < NREQ; i++) begin : g_req
    assign req[i].op = req_op[i*3 +: 3];
    assign req[i].x  = req_x[i*WIDTH +: WIDTH];
    assign req[i].y  = req_y[i*WIDTH +: WIDTH];
  end

  assign space = !rsp_valid_q || rsp_ready;

  rr_arb2 u_rr (
    .valid_i      (req_valid),
    .last_grant_i (last_grant_q),
    .space_i      (space),
    .grant_o      (grant)
  );

  assign req_ready = grant & {NREQ{!rst}};
  assign fire      = |(req_valid & req_ready);
  assign sel       = req_ready[1];
  assign sel_req   = req[sel];

  alu u_alu (
    .x        (sel_req.x),
    .y        (sel_req.y),
    .op       (sel_req.op),
    .z        (alu_z),
    .equal    (alu_equal),
    .overflow (alu_overflow),
    .zero     (alu_zero)
  );

  always_comb begin
    rsp_valid_d  = rsp_valid_q;
    rsp_d        = rsp_q;
    last_grant_d = last_grant_q;
    cnt_d        = cnt_q;
    // A fire while draining overwrites the register, giving one result per cycle.
    if (fire) begin
      rsp_valid_d    = 1'b1;
      rsp_d.id       = sel;
      rsp_d.z        = alu_z;
      rsp_d.equal    = alu_equal;
      rsp_d.overflow = alu_overflow;
      rsp_d.zero     = alu_zero;
      last_grant_d   = sel;
    end else if (rsp_ready) begin
      rsp_valid_d = 1'b0;
    end
    if ((req_valid == 2'b11) && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_valid_q  <= 1'b0;
      rsp_q        <= '0;
      last_grant_q <= 1'b1;
      cnt_q        <= '0;
    end else begin
      rsp_valid_q  <= rsp_valid_d;
      rsp_q        <= rsp_d;
      last_grant_q <= last_grant_d;
      cnt_q        <= cnt_d;
    end
  end

  assign rsp_valid    = rsp_valid_q;
  assign rsp_id       = rsp_q.id;
  assign rsp_z        = rsp_q.z;
  assign rsp_equal    = rsp_q.equal;
  assign rsp_overflow = rsp_q.overflow;
  assign rsp_zero     = rsp_q.zero;
  assign conflict_cnt = cnt_q;
endmodule

// File: tb/tb_alu_arbiter.sv
// tb/tb_alu_arbiter.sv - directed, table-driven bench for alu_arbiter
module tb_alu_arbiter;
  import alu_arb_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [1:0]  req_valid;
  logic [5:0]  req_op;
  logic [63:0] req_x, req_y;
  logic        rsp_ready;

  logic [1:0]  req_ready;
  logic        rsp_valid, rsp_id, rsp_equal, rsp_overflow, rsp_zero;
  logic [31:0] rsp_z;
  logic [15:0] conflict_cnt;

  logic [1:0]  s_req_ready;
  logic        s_rsp_valid, s_rsp_id, s_rsp_equal, s_rsp_overflow, s_rsp_zero;
  logic [31:0] s_rsp_z;
  logic [3:0]  s_conflict_cnt;

  alu_arbiter #(.WIDTH(32), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_x(req_x), .req_y(req_y),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_z(rsp_z),
    .rsp_equal(rsp_equal), .rsp_overflow(rsp_overflow), .rsp_zero(rsp_zero),
    .conflict_cnt(conflict_cnt)
  );

  alu_arbiter #(.WIDTH(32), .CNT_W(4)) dut_sat (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(s_req_ready),
    .req_op(req_op), .req_x(req_x), .req_y(req_y),
    .rsp_valid(s_rsp_valid), .rsp_ready(rsp_ready), .rsp_id(s_rsp_id), .rsp_z(s_rsp_z),
    .rsp_equal(s_rsp_equal), .rsp_overflow(s_rsp_overflow), .rsp_zero(s_rsp_zero),
    .conflict_cnt(s_conflict_cnt)
  );

  typedef struct packed {
    logic        rst;
    logic [1:0]  valid;
    logic        rr;
    logic [2:0]  op0;
    logic [31:0] x0;
    logic [31:0] y0;
    logic [2:0]  op1;
    logic [31:0] x1;
    logic [31:0] y1;
    logic [1:0]  exp_ready;
    logic        exp_vld;
    logic        chk_data;
    logic        exp_id;
    logic [31:0] exp_z;
    logic        exp_eq;
    logic        exp_ov;
    logic        exp_zero;
    logic [15:0] exp_cnt;
  } vec_t;

  int n_checks = 0;
  int n_fail   = 0;

  // Requesters must hold operands while stalled.
  logic [1:0]  stall_prev = 2'b00;
  logic [5:0]  op_prev;
  logic [63:0] x_prev, y_prev;
  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (stall_prev[i] && req_valid[i] &&
          ((req_op[i*3 +: 3] !== op_prev[i*3 +: 3]) ||
           (req_x[i*32 +: 32] !== x_prev[i*32 +: 32]) ||
           (req_y[i*32 +: 32] !== y_prev[i*32 +: 32])))
        $error("requester %0d changed operands while stalled", i);
    end
    stall_prev <= req_valid & ~req_ready;
    op_prev    <= req_op;
    x_prev     <= req_x;
    y_prev     <= req_y;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic [1:0] v, input logic rr,
                       input logic [2:0] o0, input logic [31:0] x0, input logic [31:0] y0,
                       input logic [2:0] o1, input logic [31:0] x1, input logic [31:0] y1);
    rst = r; req_valid = v; rsp_ready = rr;
    req_op = {o1, o0}; req_x = {x1, x0}; req_y = {y1, y0};
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_rsp(input string tag, input logic vld, input logic id, input logic [31:0] z,
                           input logic eq, input logic ov, input logic zr);
    check({tag, " rsp_valid"}, {31'b0, rsp_valid}, {31'b0, vld});
    check({tag, " rsp_id"}, {31'b0, rsp_id}, {31'b0, id});
    check({tag, " rsp_z"}, rsp_z, z);
    check({tag, " rsp_flags"}, {29'b0, rsp_equal, rsp_overflow, rsp_zero}, {29'b0, eq, ov, zr});
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    string tag;
    tag = $sformatf("vec%0d", idx);
    drive(v.rst, v.valid, v.rr, v.op0, v.x0, v.y0, v.op1, v.x1, v.y1);
    #3;
    check({tag, " req_ready"}, {30'b0, req_ready}, {30'b0, v.exp_ready});
    step();
    if (v.chk_data)
      check_rsp(tag, v.exp_vld, v.exp_id, v.exp_z, v.exp_eq, v.exp_ov, v.exp_zero);
    else
      check({tag, " rsp_valid"}, {31'b0, rsp_valid}, {31'b0, v.exp_vld});
    check({tag, " conflict_cnt"}, {16'b0, conflict_cnt}, {16'b0, v.exp_cnt});
  endtask

  vec_t tbl [13];

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    // reset and idle
    tbl[0]  = '{1'b1, 2'b11, 1'b0, OP_ADD, 32'h0, 32'h0, OP_ADD, 32'h0, 32'h0, 2'b00, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 16'd0};
    tbl[1]  = '{1'b1, 2'b11, 1'b0, OP_ADD, 32'h0, 32'h0, OP_ADD, 32'h0, 32'h0, 2'b00, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 16'd0};
    tbl[2]  = '{1'b0, 2'b00, 1'b1, OP_ADD, 32'h0, 32'h0, OP_ADD, 32'h0, 32'h0, 2'b00, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 16'd0};
    // single ADD on req 0, then drain
    tbl[3]  = '{1'b0, 2'b01, 1'b1, OP_ADD, 32'hFF, 32'hFF, OP_ADD, 32'h0, 32'h0, 2'b01, 1'b1, 1'b1, 1'b0, 32'h1FE, 1'b1, 1'b0, 1'b0, 16'd0};
    tbl[4]  = '{1'b0, 2'b00, 1'b1, OP_ADD, 32'hFF, 32'hFF, OP_ADD, 32'h0, 32'h0, 2'b00, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 16'd0};
    // unused op code on req 1 gives z=0
    tbl[5]  = '{1'b0, 2'b10, 1'b1, OP_ADD, 32'h0, 32'h0, OP_NOP, 32'h5, 32'h5, 2'b10, 1'b1, 1'b1, 1'b1, 32'h0, 1'b1, 1'b0, 1'b1, 16'd0};
    tbl[6]  = '{1'b0, 2'b00, 1'b1, OP_ADD, 32'h0, 32'h0, OP_NOP, 32'h5, 32'h5, 2'b00, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 16'd0};
    // reset so contention starts from last_grant=1
    tbl[7]  = '{1'b1, 2'b00, 1'b1, OP_ADD, 32'h0, 32'h0, OP_ADD, 32'h0, 32'h0, 2'b00, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 16'd0};
    tbl[8]  = '{1'b0, 2'b11, 1'b1, OP_SUB, 32'h5, 32'h5, OP_AND, 32'hFFFFFFFF, 32'h0F0F0F0F, 2'b01, 1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 16'd1};
    tbl[9]  = '{1'b0, 2'b11, 1'b1, OP_SUB, 32'h5, 32'h5, OP_AND, 32'hFFFFFFFF, 32'h0F0F0F0F, 2'b10, 1'b1, 1'b1, 1'b1, 32'h0F0F0F0F, 1'b0, 1'b0, 1'b0, 16'd2};
    tbl[10] = '{1'b0, 2'b11, 1'b1, OP_SUB, 32'h5, 32'h5, OP_AND, 32'hFFFFFFFF, 32'h0F0F0F0F, 2'b01, 1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 16'd3};
    tbl[11] = '{1'b0, 2'b11, 1'b1, OP_SUB, 32'h5, 32'h5, OP_AND, 32'hFFFFFFFF, 32'h0F0F0F0F, 2'b10, 1'b1, 1'b1, 1'b1, 32'h0F0F0F0F, 1'b0, 1'b0, 1'b0, 16'd4};
    tbl[12] = '{1'b0, 2'b00, 1'b1, OP_SUB, 32'h5, 32'h5, OP_AND, 32'hFFFFFFFF, 32'h0F0F0F0F, 2'b00, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 16'd4};

    for (int i = 0; i < 13; i++) run_vec(tbl[i], i);

    // backpressure: overflowing ADD from req 1 held while req 0 waits
    drive(1'b0, 2'b10, 1'b0, OP_OR, 32'h1, 32'h2, OP_ADD, 32'h7FFFFFFF, 32'h1);
    #3;
    check("bp accept req_ready", {30'b0, req_ready}, 32'h2);
    step();
    check_rsp("bp load", 1'b1, 1'b1, 32'h80000000, 1'b0, 1'b1, 1'b0);
    for (int k = 0; k < 3; k++) begin
      drive(1'b0, 2'b01, 1'b0, OP_OR, 32'h1, 32'h2, OP_ADD, 32'h7FFFFFFF, 32'h1);
      #3;
      check($sformatf("bp stall%0d req_ready", k), {30'b0, req_ready}, 32'h0);
      step();
      check_rsp($sformatf("bp stall%0d", k), 1'b1, 1'b1, 32'h80000000, 1'b0, 1'b1, 1'b0);
    end
    drive(1'b0, 2'b01, 1'b1, OP_OR, 32'h1, 32'h2, OP_ADD, 32'h7FFFFFFF, 32'h1);
    #3;
    check("bp release req_ready", {30'b0, req_ready}, 32'h1);
    step();
    check_rsp("bp release", 1'b1, 1'b0, 32'h3, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 2'b00, 1'b1, OP_OR, 32'h1, 32'h2, OP_ADD, 32'h7FFFFFFF, 32'h1);
    step();
    check("bp drain rsp_valid", {31'b0, rsp_valid}, 32'h0);
    check("bp conflict_cnt", {16'b0, conflict_cnt}, 32'd4);

    // reset while a response is stalled
    drive(1'b0, 2'b10, 1'b0, OP_ADD, 32'h0, 32'h0, OP_SLL, 32'h1, 32'h4);
    #3;
    check("rs accept req_ready", {30'b0, req_ready}, 32'h2);
    step();
    check_rsp("rs load", 1'b1, 1'b1, 32'h10, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 2'b00, 1'b0, OP_ADD, 32'h0, 32'h0, OP_SLL, 32'h1, 32'h4);
    step();
    check_rsp("rs hold", 1'b1, 1'b1, 32'h10, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 2'b00, 1'b0, OP_ADD, 32'h0, 32'h0, OP_SLL, 32'h1, 32'h4);
    #3;
    check("rs in reset req_ready", {30'b0, req_ready}, 32'h0);
    step();
    check_rsp("rs after reset", 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    check("rs conflict_cnt", {16'b0, conflict_cnt}, 32'd0);
    drive(1'b0, 2'b11, 1'b1, OP_ADD, 32'h2, 32'h3, OP_SUB, 32'h9, 32'h4);
    #3;
    check("rs contention req_ready", {30'b0, req_ready}, 32'h1);
    step();
    check_rsp("rs contention", 1'b1, 1'b0, 32'h5, 1'b0, 1'b0, 1'b0);

    // saturation on the 4-bit counter, fairness on the shared stream
    drive(1'b1, 2'b00, 1'b1, OP_ADD, 32'h1, 32'h1, OP_SUB, 32'h3, 32'h1);
    step();
    for (int k = 0; k < 20; k++) begin
      drive(1'b0, 2'b11, 1'b1, OP_ADD, 32'h1, 32'h1, OP_SUB, 32'h3, 32'h1);
      #3;
      check($sformatf("sat%0d req_ready", k), {30'b0, req_ready}, (k % 2 == 0) ? 32'h1 : 32'h2);
      step();
      check($sformatf("sat%0d rsp_id", k), {31'b0, rsp_id}, (k % 2 == 0) ? 32'h0 : 32'h1);
      check($sformatf("sat%0d rsp_z", k), rsp_z, 32'h2);
      check($sformatf("sat%0d cnt4", k), {28'b0, s_conflict_cnt}, (k < 15) ? 32'(k + 1) : 32'd15);
    end
    check("sat main conflict_cnt", {16'b0, conflict_cnt}, 32'd20);
    drive(1'b0, 2'b00, 1'b1, OP_ADD, 32'h1, 32'h1, OP_SUB, 32'h3, 32'h1);
    step();
    check("sat drain cnt4", {28'b0, s_conflict_cnt}, 32'd15);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
